// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx requester side.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } feeder_state_e;

   // A transfer is outstanding whenever the two toggle lines disagree.
   function automatic logic hs_pending(input logic req, input logic ack);
      return req ^ ack;
   endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port, queue status and uart_tx toggle handshake of uart_tx_feeder.
// With UART_FEEDER_TIMEOUT_EN defined it also carries timeout_cyc/timeout.
interface uart_tx_feeder_if #(
   parameter int AW = 4
`ifdef UART_FEEDER_TIMEOUT_EN
   , parameter int TO_W = 24
`endif
);
   logic          enable;
   logic          wr_valid;
   logic          wr_ready;
   logic [7:0]    wr_data;
   logic          flush;
   logic          req;
   logic          ack;
   logic [7:0]    tx_data;
   logic [AW:0]   level;
   logic          empty;
   logic          full;
   logic          busy;
`ifdef UART_FEEDER_TIMEOUT_EN
   logic [TO_W-1:0] timeout_cyc;
   logic            timeout;
`endif

   modport slave (
      input  enable, wr_valid, wr_data, flush, ack,
`ifdef UART_FEEDER_TIMEOUT_EN
      input  timeout_cyc,
      output timeout,
`endif
      output wr_ready, req, tx_data, level, empty, full, busy
   );

   modport master (
      output enable, wr_valid, wr_data, flush, ack,
`ifdef UART_FEEDER_TIMEOUT_EN
      output timeout_cyc,
      input  timeout,
`endif
      input  wr_ready, req, tx_data, level, empty, full, busy
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with read-ahead head, flush, and a level counter kept
// independently of the pointers.
module uart_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [W-1:0]  o_head,
   output logic [AW:0]   o_level,
   output logic          o_empty,
   output logic          o_full
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_level = r_level;
   assign o_head  = r_mem[r_rd_ptr];

   // Full comes from the registered level, so a same-cycle pop never admits a write.
   assign w_push = i_push && !o_full && !i_flush;
   assign w_pop  = i_pop && !o_empty && !i_flush;

   // NOTE: the storage array is deliberately left out of reset; level/pointers
   // define which entries are valid, and a resettable array costs a flop per bit.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host bytes and issues them to uart_tx one at a time over toggle req/ack.
// Define UART_FEEDER_TIMEOUT_EN for a sticky timeout on a stalled WAIT.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
`ifdef UART_FEEDER_TIMEOUT_EN
   , parameter int TO_W = 24
`endif
) (
   input logic             clk,
   input logic             rstn,
   uart_tx_feeder_if.slave bus
);

   feeder_state_e r_state;
   logic          r_req;
   logic [7:0]    r_tx_data;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [7:0]    w_head;
   logic [AW:0]   w_level;

   assign w_pop = (r_state == IDLE) && bus.enable && !w_empty &&
                  !hs_pending(r_req, bus.ack) && !bus.flush;

   uart_sync_fifo #(.W(8), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (bus.wr_valid),
      .i_data  (bus.wr_data),
      .i_pop   (w_pop),
      .i_flush (bus.flush),
      .o_head  (w_head),
      .o_level (w_level),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // NOTE: non-blocking assignments make every branch see the pre-edge req,
   // which is what the toggle handshake relies on.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_req     <= 1'b0;
         r_tx_data <= 8'h00;
      end else begin
         case (r_state)
            IDLE: if (w_pop) begin
               r_tx_data <= w_head;
               r_state   <= LOAD;
            end
            LOAD: begin
               r_req   <= ~r_req;
               r_state <= WAIT;
            end
            WAIT: if (!hs_pending(r_req, bus.ack)) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef UART_FEEDER_TIMEOUT_EN
   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout;
   logic [TO_W-1:0] w_to_nxt;

   assign w_to_nxt = r_to_cnt + TO_W'(1);

   // Counter freezes once the flag is set; req is never re-toggled here.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == LOAD)
            r_to_cnt <= '0;
         else if (r_state == WAIT && !r_timeout)
            r_to_cnt <= w_to_nxt;

         if (bus.flush)
            r_timeout <= 1'b0;
         else if (r_state == WAIT && !r_timeout && bus.timeout_cyc != '0 &&
                  w_to_nxt == bus.timeout_cyc)
            r_timeout <= 1'b1;
      end
   end

   assign bus.timeout = r_timeout;
`endif

   assign bus.wr_ready = !w_full;
   assign bus.req      = r_req;
   assign bus.tx_data  = r_tx_data;
   assign bus.level    = w_level;
   assign bus.empty    = w_empty;
   assign bus.full     = w_full;
   assign bus.busy     = (r_state != IDLE) || hs_pending(r_req, bus.ack);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: models the uart_tx ack side and scoreboards issued bytes.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef struct {
      logic       wr_valid;
      logic [7:0] wr_data;
      logic       flush;
      logic [4:0] exp_level;
      logic       exp_full;
      logic       exp_wr_ready;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

`ifdef UART_FEEDER_TIMEOUT_EN
   uart_tx_feeder_if #(.AW(AW), .TO_W(24)) bus ();
   uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .TO_W(24)) dut (
      .clk(clk), .rstn(rstn), .bus(bus));
`else
   uart_tx_feeder_if #(.AW(AW)) bus ();
   uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .bus(bus));
`endif

   int         n_checks  = 0;
   int         n_fail    = 0;
   int         n_issued  = 0;
   logic [7:0] exp_q[$];
   bit         mon_en    = 1'b0;
   bit         ack_en    = 1'b1;
   int         ack_delay = 3;
   logic       prev_req  = 1'b0;
   logic       prev_ack  = 1'b0;
   vec_t       vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      if (!bus.flush && exp_q.size() < DEPTH) exp_q.push_back(d);
      step();
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         done = !bus.busy && (bus.level == '0);
         if (!done) step();
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic wait_toggle(input int max, input string name);
      logic r0;
      bit   seen;
      r0   = bus.req;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         step();
         seen = (bus.req != r0);
      end
      check(name, 32'(seen), 32'd1);
   endtask

   // uart_tx stand-in: answers a pending request after ack_delay cycles.
   initial begin : ack_model
      int cnt;
      cnt     = 0;
      bus.ack = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (!rstn) begin
            bus.ack = 1'b0;
            cnt     = 0;
         end else if (ack_en && bus.req != bus.ack) begin
            if (cnt >= ack_delay) begin
               bus.ack = bus.req;
               cnt     = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Every req toggle must come from an idle handshake and carry the next expected byte.
   always @(negedge clk) begin
      if (mon_en && bus.req != prev_req) begin
         check("toggle_while_pending", 32'(prev_req ^ prev_ack), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_req_toggle", 32'(bus.tx_data), 32'hFFFF_FFFF);
         end else begin
            check("tx_data_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
         end
         n_issued++;
      end
      prev_req = bus.req;
      prev_ack = bus.ack;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int issued0;

      for (int i = 0; i < 16; i++)
         vecs[i] = '{1'b1, 8'(i), 1'b0, 5'(i + 1), (i == 15), (i != 15)};
      vecs[16] = '{1'b1, 8'hEE, 1'b0, 5'd16, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0};

      bus.enable   = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'h00;
      bus.flush    = 1'b0;
`ifdef UART_FEEDER_TIMEOUT_EN
      bus.timeout_cyc = '0;
`endif

      // Reset state
      rstn = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      check("rst_req",      32'(bus.req),      32'd0);
      check("rst_tx_data",  32'(bus.tx_data),  32'd0);
      check("rst_level",    32'(bus.level),    32'd0);
      check("rst_empty",    32'(bus.empty),    32'd1);
      check("rst_full",     32'(bus.full),     32'd0);
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      mon_en = 1'b1;

      // Single byte latency: write at N, tx_data after N+1, req toggles at N+2
      bus.enable = 1'b1;
      ack_delay  = 20;
      write_byte(8'h41);
      check("t1_req_at_n",     32'(bus.req),     32'd0);
      check("t1_level_at_n",   32'(bus.level),   32'd1);
      step();
      check("t1_tx_data_n1",   32'(bus.tx_data), 32'h41);
      check("t1_req_at_n1",    32'(bus.req),     32'd0);
      step();
      check("t1_req_at_n2",    32'(bus.req),     32'd1);
      check("t1_busy_pending", 32'(bus.busy),    32'd1);
      wait_idle(200, "t1_idle");
      check("t1_ack_matched",  32'(bus.ack),     32'd1);
      check("t1_issued",       32'(n_issued),    32'd1);

      // Fill to full with enable=0, overflow write ignored
      bus.enable = 1'b0;
      for (int i = 0; i < 18; i++) begin
         bus.wr_valid = vecs[i].wr_valid;
         bus.wr_data  = vecs[i].wr_data;
         bus.flush    = vecs[i].flush;
         if (vecs[i].wr_valid && !vecs[i].flush && exp_q.size() < DEPTH)
            exp_q.push_back(vecs[i].wr_data);
         step();
         check($sformatf("vec%0d_level", i),    32'(bus.level),    32'(vecs[i].exp_level));
         check($sformatf("vec%0d_full", i),     32'(bus.full),     32'(vecs[i].exp_full));
         check($sformatf("vec%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vecs[i].exp_wr_ready));
         check($sformatf("vec%0d_empty", i),    32'(bus.empty),    32'(vecs[i].exp_level == 5'd0));
      end
      bus.wr_valid = 1'b0;

      // Write on the pop cycle while full is rejected
      issued0      = n_issued;
      bus.enable   = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hAA;
      step();
      bus.wr_valid = 1'b0;
      check("t5_level_after_pop", 32'(bus.level),    32'd15);
      check("t5_full_after_pop",  32'(bus.full),     32'd0);
      check("t5_wr_ready",        32'(bus.wr_ready), 32'd1);
      ack_delay = 2;
      wait_idle(2000, "t2_drain");
      check("t2_issued_count", 32'(n_issued - issued0), 32'd16);
      check("t2_queue_empty",  32'(exp_q.size()),       32'd0);

      // Flush while byte 0 is in WAIT
      bus.enable = 1'b0;
      for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
      check("t3_level_queued", 32'(bus.level), 32'd5);
      issued0    = n_issued;
      ack_delay  = 30;
      bus.enable = 1'b1;
      wait_toggle(20, "t3_first_toggle");
      bus.flush    = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h99;
      step();
      bus.flush    = 1'b0;
      bus.wr_valid = 1'b0;
      exp_q.delete();
      check("t3_level_flushed", 32'(bus.level), 32'd0);
      check("t3_empty_flushed", 32'(bus.empty), 32'd1);
      check("t3_busy_in_wait",  32'(bus.busy),  32'd1);
      wait_idle(200, "t3_byte0_done");
      repeat (40) step();
      check("t3_issued_once",   32'(n_issued - issued0), 32'd1);
      check("t3_no_pending",    32'(bus.req ^ bus.ack),  32'd0);

      // Reset mid-frame with 8 queued
      bus.enable = 1'b0;
      for (int i = 0; i < 8; i++) write_byte(8'hC0 + 8'(i));
      issued0    = n_issued;
      bus.enable = 1'b1;
      wait_toggle(20, "t4_first_toggle");
      mon_en = 1'b0;
      rstn   = 1'b0;
      step();
      rstn = 1'b1;
      exp_q.delete();
      check("t4_req_reset",   32'(bus.req),     32'd0);
      check("t4_level_reset", 32'(bus.level),   32'd0);
      check("t4_busy_reset",  32'(bus.busy),    32'd0);
      check("t4_empty_reset", 32'(bus.empty),   32'd1);
      check("t4_txd_reset",   32'(bus.tx_data), 32'd0);
      step();
      mon_en = 1'b1;
      repeat (60) step();
      check("t4_no_toggles",  32'(n_issued - issued0), 32'd0);
      check("t4_req_stays_0", 32'(bus.req),            32'd0);

`ifdef UART_FEEDER_TIMEOUT_EN
      // Stalled uart_tx: timeout exactly 100 cycles after the LOAD edge
      bus.enable      = 1'b0;
      ack_en          = 1'b0;
      bus.timeout_cyc = 24'd100;
      write_byte(8'h5A);
      bus.enable = 1'b1;
      wait_toggle(20, "t6_toggle");
      check("t6_timeout_at_load", 32'(bus.timeout), 32'd0);
      repeat (99) step();
      check("t6_timeout_99", 32'(bus.timeout), 32'd0);
      step();
      check("t6_timeout_100", 32'(bus.timeout), 32'd1);
      check("t6_req_held",    32'(bus.req),     32'd1);
      repeat (20) step();
      check("t6_timeout_sticky", 32'(bus.timeout), 32'd1);
      check("t6_still_busy",     32'(bus.busy),    32'd1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("t6_flush_clears", 32'(bus.timeout), 32'd0);
      check("t6_req_after",    32'(bus.req),     32'd1);
      bus.enable = 1'b0;
      mon_en     = 1'b0;
      rstn       = 1'b0;
      step();
      rstn = 1'b1;
      exp_q.delete();
      ack_en = 1'b1;
      step();
      mon_en = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
